coin_acceptor: RTL and testbench
================================

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable samples needed to accept a raw level (legal range 2..15).
REQ-002 Parameter FIFO_DEPTH, default 4, number of validated coins buffered; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 coin1_raw  input  1  unfiltered sensor, 1-unit coin slot (asynchronous, bouncy).
REQ-006 coin2_raw  input  1  unfiltered sensor, 2-unit coin slot.
REQ-007 vm_ready  input  1  downstream vending FSM can take a coin pulse this cycle.
REQ-008 coin1  output  1  one-cycle strobe: one 1-unit coin delivered downstream.
REQ-009 coin2  output  1  one-cycle strobe: one 2-unit coin delivered downstream.
REQ-010 coin_return  output  1  one-cycle strobe: a validated coin was rejected and is physically returned.
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH+1)  coins currently buffered.

Function
REQ-012 Each raw input SHALL pass through a two-flop synchronizer, then a debouncer; the debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-013 A rising edge of a debounced level SHALL create exactly one coin event; falling edges create none; a coin held high indefinitely yields one event.
REQ-014 A lone event SHALL be written to the FIFO (entry 1 bit: 0 = 1-unit, 1 = 2-unit) in the cycle after it is raised.
REQ-015 Events from both slots in the same cycle SHALL both be rejected: no FIFO write, coin_return pulses for one cycle.
REQ-016 An event arriving with fifo_count == FIFO_DEPTH SHALL be rejected with a coin_return pulse; FIFO contents unchanged.
REQ-017 Output FSM states: IDLE, ISSUE, GAP. IDLE->ISSUE when FIFO non-empty and vm_ready=1; ISSUE->GAP always; GAP->IDLE always.
REQ-018 In ISSUE exactly one of coin1/coin2 SHALL be high, selected by the FIFO head, which is popped at the end of ISSUE; in IDLE and GAP both are low.
REQ-019 GAP guarantees at least one low cycle between consecutive strobes, so a Moore consumer sees distinct coins.
REQ-020 vm_ready falling while in ISSUE SHALL NOT abort the strobe in progress; vm_ready is sampled only in IDLE.
REQ-021 A FIFO push and pop in the same cycle SHALL leave fifo_count unchanged and preserve order; delivery is strictly first-in first-out.
REQ-022 End-to-end latency with FIFO empty, FSM IDLE, vm_ready=1: strobe high in cycle DEBOUNCE_CYCLES+4 counting the first cycle raw is high as cycle 0 (2 sync + DEBOUNCE_CYCLES + edge + write).
REQ-023 coin1, coin2 and coin_return SHALL never be high for two consecutive cycles.

Reset
REQ-024 While rst=1 at a clock edge: FSM -> IDLE, FIFO pointers and fifo_count -> 0, synchronizers and debounced levels -> 0, debounce counters -> 0.
REQ-025 All outputs SHALL be 0 in the cycle after a reset edge; a reset during ISSUE truncates the strobe and discards buffered coins without coin_return.
REQ-026 A raw input already high when rst deasserts SHALL be debounced normally and produce one event.

Configuration
REQ-027 Macro COIN_ACCEPTOR_CREDIT_EN: when defined, adds output credit_total (8 bits), incremented by 1 on each coin1 strobe and by 2 on each coin2 strobe, saturating at 255, cleared by reset.
REQ-028 Without COIN_ACCEPTOR_CREDIT_EN the credit_total port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 Shared package vm_pkg SHALL hold the coin-type encoding (COIN_1U=0, COIN_2U=1), the output FSM state encoding, and the credit width constant.
REQ-030 Sub-module coin_debounce (synchronizer + debounce counter + rising-edge event) SHALL be instantiated once per slot; FIFO and FSM reside in coin_acceptor.

Verification (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4)
REQ-031 coin1_raw high from cycle 0, held, vm_ready=1 -> coin1 high in cycle 8 only; no further strobe while held.
REQ-032 coin2_raw toggling every cycle for 10 cycles, then low -> no event, no strobe, fifo_count stays 0.
REQ-033 vm_ready=0, five clean alternating coins (1,2,1,2,1) -> fifo_count reaches 4, fifth coin gives coin_return; then vm_ready=1 -> coin1,coin2,coin1,coin2 strobes each separated by exactly 2 low cycles.
REQ-034 coin1_raw and coin2_raw rising in the same cycle, both clean -> coin_return pulse once, no coin strobe, fifo_count 0.
REQ-035 Three coins buffered, rst pulsed for 1 cycle during ISSUE -> next cycle all outputs 0, fifo_count 0, no later strobes.
REQ-036 With COIN_ACCEPTOR_CREDIT_EN: 130 coin2 strobes -> credit_total holds 255 (saturated).

Source files
------------

// File: rtl/vm_pkg.sv
// ---------------------------------------------------------------------------
// vm_pkg
// Shared definitions for the coin acceptor front end of the vending machine:
//   - coin_t      : coin-type encoding stored in the coin FIFO
//   - state_t     : output strobe FSM state encoding
//   - CREDIT_W    : width of the optional running credit total
//   - credit_add  : saturating credit accumulation helper
// ---------------------------------------------------------------------------
package vm_pkg;

  typedef enum logic {
    COIN_1U = 1'b0,
    COIN_2U = 1'b1
  } coin_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int CREDIT_W = 8;

  // Adds a small increment (0..3 units) to the credit total and clamps at
  // the all-ones value instead of wrapping.
  function automatic logic [CREDIT_W-1:0] credit_add(
    input logic [CREDIT_W-1:0] total,
    input logic [1:0]          inc
  );
    logic [CREDIT_W:0] sum;
    sum = {1'b0, total} + {{(CREDIT_W - 1){1'b0}}, inc};
    if (sum[CREDIT_W]) begin
      return {CREDIT_W{1'b1}};
    end else begin
      return sum[CREDIT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// ---------------------------------------------------------------------------
// coin_debounce
// One coin slot front end: two-flop synchronizer, debounce counter and
// rising-edge detector producing a single-cycle coin event.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   raw         in   unfiltered, asynchronous coin sensor level
//   coin_event  out  one-cycle pulse, one per debounced rising edge
//
// The debounced level follows the synchronized input only after
// DEBOUNCE_CYCLES consecutive samples that all differ from the current
// level. The event is registered one cycle after the level rises.
// ---------------------------------------------------------------------------
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic coin_event
);

  // DEBOUNCE_CYCLES is at most 15, so four bits always hold the count.
  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          level_d_r;
  logic          event_r;
  logic [CW-1:0] cnt_r;

  // Synchronizer, debounce counter, debounced level and edge event.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      level_r   <= 1'b0;
      level_d_r <= 1'b0;
      event_r   <= 1'b0;
      cnt_r     <= '0;
    end else begin
      sync1_r   <= raw;
      sync2_r   <= sync1_r;
      level_d_r <= level_r;
      event_r   <= level_r & ~level_d_r;
      // cnt_r counts consecutive samples that disagree with the level; the
      // sample that completes the run flips the level and restarts the count.
      if (sync2_r != level_r) begin
        if (cnt_r == CNT_LAST) begin
          level_r <= sync2_r;
          cnt_r   <= '0;
        end else begin
          level_r <= level_r;
          cnt_r   <= cnt_r + 4'd1;
        end
      end else begin
        level_r <= level_r;
        cnt_r   <= '0;
      end
    end
  end

  assign coin_event = event_r;

endmodule

// File: rtl/coin_acceptor.sv
// ---------------------------------------------------------------------------
// coin_acceptor
// Filters two coin sensors, buffers validated coins in a small FIFO and
// hands them to the vending FSM as single-cycle strobes separated by at
// least one low cycle.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset
//   coin1_raw     in   raw sensor, 1-unit slot
//   coin2_raw     in   raw sensor, 2-unit slot
//   vm_ready      in   downstream can accept a coin strobe (sampled in IDLE)
//   coin1         out  one-cycle strobe, 1-unit coin delivered
//   coin2         out  one-cycle strobe, 2-unit coin delivered
//   coin_return   out  one-cycle strobe, a validated coin is returned
//   fifo_count    out  number of coins currently buffered
//   credit_total  out  (COIN_ACCEPTOR_CREDIT_EN only) saturating credit sum
//
// Build option: define COIN_ACCEPTOR_CREDIT_EN to add credit_total.
// ---------------------------------------------------------------------------
module coin_acceptor
  import vm_pkg::*;
#(
  parameter  int DEBOUNCE_CYCLES = 4,
  parameter  int FIFO_DEPTH      = 4,
  localparam int CNT_W           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coin1_raw,
  input  logic             coin2_raw,
  input  logic             vm_ready,
  output logic             coin1,
  output logic             coin2,
  output logic             coin_return,
  output logic [CNT_W-1:0] fifo_count
`ifdef COIN_ACCEPTOR_CREDIT_EN
  ,
  output logic [CREDIT_W-1:0] credit_total
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic             ev1;
  logic             ev2;
  logic             push;
  logic             pop;
  logic             reject;
  coin_t            push_type;
  coin_t            head;
  coin_t            mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next;
  state_t           state_r;
  state_t           state_next;
  logic             coin1_r;
  logic             coin2_r;
  logic             ret_r;
  logic             ret_fire;
  logic [1:0]       owed_r;
  logic [1:0]       owed_next;

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .raw       (coin1_raw),
    .coin_event(ev1)
  );

  coin_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_slot2 (
    .clk       (clk),
    .rst       (rst),
    .raw       (coin2_raw),
    .coin_event(ev2)
  );

  assign head = mem_r[rd_ptr_r];
  assign pop  = (state_r == ST_ISSUE);

  // Arrival arbitration: simultaneous coins are ambiguous and both go back;
  // a lone coin is buffered unless the FIFO is already full.
  always_comb begin
    push      = 1'b0;
    reject    = 1'b0;
    push_type = COIN_1U;
    if (ev1 && ev2) begin
      reject = 1'b1;
    end else if (ev1 || ev2) begin
      push_type = ev2 ? COIN_2U : COIN_1U;
      if (count_r == CNT_FULL) begin
        reject = 1'b1;
      end else begin
        push = 1'b1;
      end
    end else begin
      push   = 1'b0;
      reject = 1'b0;
    end
  end

  // Occupancy update; a simultaneous push and pop leaves the count as is.
  always_comb begin
    count_next = count_r;
    case ({push, pop})
      2'b10:   count_next = count_r + CNT_W'(1);
      2'b01:   count_next = count_r - CNT_W'(1);
      default: count_next = count_r;
    endcase
  end

  // Output FSM next state; vm_ready only matters while idle.
  always_comb begin
    state_next = state_r;
    case (state_r)
      ST_IDLE: begin
        if ((count_r != '0) && vm_ready) begin
          state_next = ST_ISSUE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ISSUE: state_next = ST_GAP;
      ST_GAP:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Return scheduling: a rejection that lands right after another return
  // pulse is held in owed_r so coin_return never stays high two cycles.
  always_comb begin
    ret_fire  = ~ret_r & (reject | (owed_r != 2'd0));
    owed_next = owed_r;
    case ({reject, ret_fire})
      2'b10:   owed_next = owed_r + 2'd1;
      2'b01:   owed_next = owed_r - 2'd1;
      default: owed_next = owed_r;
    endcase
  end

  // FIFO storage; data needs no reset because the pointers qualify it.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_r[wr_ptr_r] <= push_type;
    end
  end

  // FIFO pointers, occupancy and return bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      owed_r   <= 2'd0;
      ret_r    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_next;
      owed_r  <= owed_next;
      ret_r   <= ret_fire;
    end
  end

  // FSM state and registered strobes; the strobe type is taken from the
  // FIFO head, which stays put until the pop at the end of ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      coin1_r <= 1'b0;
      coin2_r <= 1'b0;
    end else begin
      state_r <= state_next;
      coin1_r <= (state_next == ST_ISSUE) && (head == COIN_1U);
      coin2_r <= (state_next == ST_ISSUE) && (head == COIN_2U);
    end
  end

  assign coin1       = coin1_r;
  assign coin2       = coin2_r;
  assign coin_return = ret_r;
  assign fifo_count  = count_r;

`ifdef COIN_ACCEPTOR_CREDIT_EN
  logic [CREDIT_W-1:0] credit_r;

  // Credit accumulates one cycle behind each strobe; {coin2, coin1} is
  // directly the unit value of the coin being delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_r <= '0;
    end else begin
      credit_r <= credit_add(credit_r, {coin2_r, coin1_r});
    end
  end

  assign credit_total = credit_r;
`else
  // No credit tracking in this build.
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4).
// A reference model built from the behavioural rules (stable-window
// debounce, coin queue, IDLE/ISSUE/GAP phases) predicts every output each
// cycle; directed scenarios add end-to-end checks.
module tb_coin_acceptor;

  localparam int D  = 4;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin1_raw = 1'b0;
  logic       coin2_raw = 1'b0;
  logic       vm_ready = 1'b0;
  logic       coin1;
  logic       coin2;
  logic       coin_return;
  logic [2:0] fifo_count;
`ifdef COIN_ACCEPTOR_CREDIT_EN
  logic [7:0] credit_total;
`endif

  always #5 clk = ~clk;

  coin_acceptor #(
    .DEBOUNCE_CYCLES(D),
    .FIFO_DEPTH     (FD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .coin1_raw  (coin1_raw),
    .coin2_raw  (coin2_raw),
    .vm_ready   (vm_ready),
    .coin1      (coin1),
    .coin2      (coin2),
    .coin_return(coin_return),
    .fifo_count (fifo_count)
`ifdef COIN_ACCEPTOR_CREDIT_EN
    ,
    .credit_total(credit_total)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  int cyc = 0;
  int hist[2][8];          // raw samples seen at past edges, newest at [0]
  int lvl[2];              // debounced level per slot
  int due[2] = '{-1, -1};  // edge at which a detected coin reaches the FIFO
  bit q[$];                // buffered coins, 1 = 2-unit
  int phase = 0;           // 0 idle, 1 issuing, 2 gap
  int owed = 0;            // returns waiting for a free cycle
  int e_c1 = 0;
  int e_c2 = 0;
  int e_ret = 0;
  int e_credit = 0;

  // observations for directed scenarios
  int n_strobe = 0;
  int n_ret = 0;
  int max_cnt = 0;
  int tick_idx = 0;
  int st_cyc[$];
  int st_typ[$];

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (model edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  // 1 if the last D synchronized samples are all high, 0 if all low, else -1
  function automatic int win(input int s);
    int ones = 0;
    for (int i = 1; i <= D; i++) ones += hist[s][i];
    if (ones == D) return 1;
    else if (ones == 0) return 0;
    else return -1;
  endfunction

  task automatic model_edge(input bit r1, input bit r2, input bit vr, input bit rs);
    int  pre_size;
    bit  a[2];
    bit  req;
    bit  start;
    int  w;
    int  raw_v[2];
    cyc++;
    raw_v[0] = r1;
    raw_v[1] = r2;
    if (rs) begin
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < 8; i++) hist[s][i] = 0;
        lvl[s] = 0;
        due[s] = -1;
      end
      q.delete();
      phase = 0; owed = 0;
      e_c1 = 0; e_c2 = 0; e_ret = 0; e_credit = 0;
    end else begin
      pre_size = q.size();
      for (int s = 0; s < 2; s++) a[s] = (due[s] == cyc);
      e_credit = e_credit + e_c1 + 2 * e_c2;
      if (e_credit > 255) e_credit = 255;
      start = (phase == 0) && (pre_size > 0) && vr;
      e_c1 = 0;
      e_c2 = 0;
      if (start) begin
        e_c1 = (q[0] == 1'b0);
        e_c2 = (q[0] == 1'b1);
      end
      if (phase == 1) void'(q.pop_front());
      phase = start ? 1 : ((phase == 1) ? 2 : 0);
      req = 1'b0;
      if (a[0] && a[1]) req = 1'b1;
      else if (a[0] || a[1]) begin
        if (pre_size == FD) req = 1'b1;
        else q.push_back(a[1]);
      end
      owed += int'(req);
      if (e_ret == 0 && owed > 0) begin
        e_ret = 1;
        owed--;
      end else begin
        e_ret = 0;
      end
      for (int s = 0; s < 2; s++) begin
        w = win(s);
        if (w >= 0 && w != lvl[s]) begin
          lvl[s] = w;
          if (w == 1) due[s] = cyc + 2;
        end
        for (int i = 7; i > 0; i--) hist[s][i] = hist[s][i-1];
        hist[s][0] = raw_v[s];
      end
    end
  endtask

  task automatic tick(input bit r1, input bit r2, input bit vr, input bit rs);
    coin1_raw = r1;
    coin2_raw = r2;
    vm_ready  = vr;
    rst       = rs;
    @(posedge clk);
    model_edge(r1, r2, vr, rs);
    #1;
    check_eq("coin1", int'(coin1), e_c1);
    check_eq("coin2", int'(coin2), e_c2);
    check_eq("coin_return", int'(coin_return), e_ret);
    check_eq("fifo_count", int'(fifo_count), q.size());
`ifdef COIN_ACCEPTOR_CREDIT_EN
    check_eq("credit_total", int'(credit_total), e_credit);
`endif
    if (coin1 === 1'b1 || coin2 === 1'b1) begin
      n_strobe++;
      st_cyc.push_back(tick_idx);
      st_typ.push_back((coin2 === 1'b1) ? 2 : 1);
    end
    if (coin_return === 1'b1) n_ret++;
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    tick_idx++;
  endtask

  task automatic coin_pulse(input bit s1, input bit s2, input int hold, input int low, input bit vr);
    for (int i = 0; i < hold; i++) tick(s1, s2, vr, 1'b0);
    for (int i = 0; i < low; i++) tick(1'b0, 1'b0, vr, 1'b0);
  endtask

  task automatic clear_obs();
    n_strobe = 0; n_ret = 0; max_cnt = 0; tick_idx = 0;
    st_cyc.delete();
    st_typ.delete();
  endtask

  initial begin
    int guard;
    int len;
    int vr_bias;
    bit b1, b2, bounce, r1, r2, vr, rs;

    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("rst_fifo_count", int'(fifo_count), 0);
    check_eq("rst_outputs", int'(coin1 | coin2 | coin_return), 0);
    repeat (2) tick(1'b0, 1'b0, 1'b1, 1'b0);

    // held 1-unit coin: strobe exactly at cycle D+4, only once
    clear_obs();
    repeat (25) tick(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("latency_strobes", n_strobe, 1);
    check_eq("latency_cycle", (st_cyc.size() > 0) ? st_cyc[0] : -1, D + 4);
    check_eq("latency_type", (st_typ.size() > 0) ? st_typ[0] : -1, 1);
    repeat (12) tick(1'b0, 1'b0, 1'b1, 1'b0);

    // bouncing coin2 sensor never settles: nothing happens
    clear_obs();
    for (int i = 0; i < 10; i++) tick(1'b0, (i % 2) == 0, 1'b1, 1'b0);
    repeat (12) tick(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("bounce_strobes", n_strobe, 0);
    check_eq("bounce_max_count", max_cnt, 0);
    check_eq("bounce_returns", n_ret, 0);

    // fill FIFO with vm_ready low, fifth coin returned, then drain in order
    clear_obs();
    for (int k = 0; k < 5; k++) coin_pulse((k % 2) == 0, (k % 2) == 1, 6, 6, 1'b0);
    repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("full_count", int'(fifo_count), 4);
    check_eq("full_returns", n_ret, 1);
    clear_obs();
    repeat (16) tick(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("drain_strobes", n_strobe, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_type", (i < st_typ.size()) ? st_typ[i] : -1, (i % 2 == 0) ? 1 : 2);
      if (i > 0) check_eq("drain_spacing", (i < st_cyc.size()) ? st_cyc[i] - st_cyc[i-1] : -1, 3);
    end

    // both slots at once: one return, no strobe
    clear_obs();
    coin_pulse(1'b1, 1'b1, 6, 8, 1'b1);
    check_eq("dual_returns", n_ret, 1);
    check_eq("dual_strobes", n_strobe, 0);
    check_eq("dual_count", int'(fifo_count), 0);

    // reset during ISSUE discards everything
    clear_obs();
    coin_pulse(1'b1, 1'b0, 6, 6, 1'b0);
    coin_pulse(1'b0, 1'b1, 6, 6, 1'b0);
    coin_pulse(1'b1, 1'b0, 6, 6, 1'b0);
    guard = 0;
    do begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      guard++;
    end while (!(coin1 === 1'b1 || coin2 === 1'b1) && guard < 10);
    check_eq("issue_reached", int'(coin1 | coin2), 1);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("rst_issue_outputs", int'(coin1 | coin2 | coin_return), 0);
    check_eq("rst_issue_count", int'(fifo_count), 0);
    clear_obs();
    repeat (15) tick(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("rst_issue_later", n_strobe + n_ret, 0);

    // randomized segments against the model
    for (int it = 0; it < 300; it++) begin
      len     = $urandom_range(1, 9);
      b1      = 1'($urandom_range(0, 1));
      b2      = 1'($urandom_range(0, 1));
      bounce  = ($urandom_range(0, 3) == 0);
      vr_bias = $urandom_range(0, 4);
      for (int t = 0; t < len; t++) begin
        r1 = bounce ? 1'($urandom_range(0, 1)) : b1;
        r2 = bounce ? 1'($urandom_range(0, 1)) : b2;
        vr = ($urandom_range(0, 3) < vr_bias);
        rs = ($urandom_range(0, 199) == 0);
        tick(r1, r2, vr, rs);
      end
    end

`ifdef COIN_ACCEPTOR_CREDIT_EN
    clear_obs();
    repeat (130) coin_pulse(1'b0, 1'b1, 6, 6, 1'b1);
    repeat (4) tick(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("credit_saturated", int'(credit_total), 255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
